// File: rtl/noc_inject_arbiter_if.sv
// noc_inject_arbiter_if: requester-side and router-side signal bundle for the injection arbiter
interface noc_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  parameter int N_ADDR_WIDTH = 4,
  parameter int VC_ADDR_WIDTH = 1
);
  logic [NUM_REQ*WIDTH-1:0]         req_data_in;
  logic [NUM_REQ*N_ADDR_WIDTH-1:0]  req_dest_in;
  logic [NUM_REQ*VC_ADDR_WIDTH-1:0] req_vc_in;
  logic [NUM_REQ-1:0]               req_valid_in;
  logic [NUM_REQ-1:0]               req_ready_out;
  logic [WIDTH-1:0]                 out_data_out;
  logic [N_ADDR_WIDTH-1:0]          out_dest_out;
  logic [VC_ADDR_WIDTH-1:0]         out_vc_out;
  logic                             out_valid_out;
  logic                             out_ready_in;
  logic [NUM_REQ-1:0]               grant_out;
  modport master (
    output req_data_in, req_dest_in, req_vc_in, req_valid_in, out_ready_in,
    input  req_ready_out, out_data_out, out_dest_out, out_vc_out, out_valid_out, grant_out
  );
  modport slave (
    input  req_data_in, req_dest_in, req_vc_in, req_valid_in, out_ready_in,
    output req_ready_out, out_data_out, out_dest_out, out_vc_out, out_valid_out, grant_out
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin injection-port arbiter with bounded burst lock and registered output stage
module noc_inject_arbiter #(
  parameter int N = 16,
  parameter int NUM_VC = 2,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  parameter int MAX_BURST = 1
) (
  input logic clk,
  input logic rst,
  noc_inject_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  logic [OW-1:0]            owner_q, owner_d, win, idx;
  logic [7:0]               burst_q, burst_d;
  logic                     lock_q, lock_d, valid_q, valid_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic [N_ADDR_WIDTH-1:0]  dest_q, dest_d;
  logic [VC_ADDR_WIDTH-1:0] vc_q, vc_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     load_en, take;
  always_comb begin
    win = owner_q;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(owner_q) + k) % NUM_REQ);
      if (bus.req_valid_in[idx]) win = idx;
    end
    if (lock_q && bus.req_valid_in[owner_q] && burst_q < 8'(MAX_BURST)) win = owner_q;
  end
  assign load_en = !valid_q || bus.out_ready_in;
  assign take = !rst && load_en && |bus.req_valid_in;
  assign bus.req_ready_out = take ? NUM_REQ'(1) << win : '0;
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    lock_d  = lock_q;
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    vc_d    = vc_q;
    grant_d = grant_q;
    if (take) begin
      owner_d = win;
      burst_d = (lock_q && win == owner_q) ? (burst_q == 8'hff ? burst_q : burst_q + 8'd1) : 8'd1;
      lock_d  = 1'b1;
      valid_d = 1'b1;
      grant_d = NUM_REQ'(1) << win;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win == OW'(i)) begin
          data_d = bus.req_data_in[i*WIDTH +: WIDTH];
          dest_d = bus.req_dest_in[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
          vc_d   = bus.req_vc_in[i*VC_ADDR_WIDTH +: VC_ADDR_WIDTH];
        end
      end
    end else if (valid_q && bus.out_ready_in) begin
      valid_d = 1'b0;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OW'(NUM_REQ - 1);
      burst_q <= '0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      vc_q    <= '0;
      grant_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      vc_q    <= vc_d;
      grant_q <= grant_d;
    end
  end
  assign bus.out_data_out  = data_q;
  assign bus.out_dest_out  = dest_q;
  assign bus.out_vc_out    = vc_q;
  assign bus.out_valid_out = valid_q;
  assign bus.grant_out     = grant_q;
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: scoreboard bench for round-robin, backpressure, burst lock, sparse traffic and reset
module tb_noc_inject_arbiter;
  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] d;
    logic [3:0]  dest;
    logic        vc;
  } flit_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  flit_t qa[$];
  flit_t qb[$];
  logic [31:0] d_a[4], d_b[4];
  logic [3:0]  dest_a[4], dest_b[4];
  logic        vc_a[4], vc_b[4];
  always #5 clk = ~clk;
  noc_inject_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) ifa ();
  noc_inject_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) ifb ();
  noc_inject_arbiter #(.N(16), .NUM_VC(2), .NUM_REQ(4), .WIDTH(32), .MAX_BURST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  noc_inject_arbiter #(.N(16), .NUM_VC(2), .NUM_REQ(4), .WIDTH(32), .MAX_BURST(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign ifa.req_data_in[i*32 +: 32] = d_a[i];
    assign ifa.req_dest_in[i*4 +: 4]   = dest_a[i];
    assign ifa.req_vc_in[i]            = vc_a[i];
    assign ifb.req_data_in[i*32 +: 32] = d_b[i];
    assign ifb.req_dest_in[i*4 +: 4]   = dest_b[i];
    assign ifb.req_vc_in[i]            = vc_b[i];
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  function automatic flit_t mk_a(input int i);
    mk_a = '{g: 4'(1 << i), d: d_a[i], dest: dest_a[i], vc: vc_a[i]};
  endfunction
  function automatic flit_t mk_b(input int i);
    mk_b = '{g: 4'(1 << i), d: d_b[i], dest: dest_b[i], vc: vc_b[i]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (ifa.out_valid_out && ifa.out_ready_in) begin
      if (qa.size() == 0) chk("a_unexpected_flit", 64'(ifa.grant_out), 64'h0);
      else chk("a_flit", 64'({ifa.grant_out, ifa.out_data_out, ifa.out_dest_out, ifa.out_vc_out}), 64'(qa.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (ifb.out_valid_out && ifb.out_ready_in) begin
      if (qb.size() == 0) chk("b_unexpected_flit", 64'(ifb.grant_out), 64'h0);
      else chk("b_flit", 64'({ifb.grant_out, ifb.out_data_out, ifb.out_dest_out, ifb.out_vc_out}), 64'(qb.pop_front()));
    end
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      d_a[i] = 32'hA000_0000 + 32'(i * 32'h11);
      dest_a[i] = 4'(i + 8);
      vc_a[i] = i[0];
      d_b[i] = 32'hB000_0000 + 32'(i);
      dest_b[i] = 4'(i + 2);
      vc_b[i] = ~i[0];
    end
    ifa.req_valid_in = 4'b1111;
    ifa.out_ready_in = 1'b1;
    ifb.req_valid_in = 4'b0000;
    ifb.out_ready_in = 1'b1;
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_valid", 64'(ifa.out_valid_out), 64'h0);
      chk("rst_grant", 64'(ifa.grant_out), 64'h0);
      chk("rst_ready", 64'(ifa.req_ready_out), 64'h0);
    end
    foreach (qa[i]) n_run += 0;
    qa.push_back(mk_a(0));
    qa.push_back(mk_a(1));
    qa.push_back(mk_a(2));
    qa.push_back(mk_a(3));
    qa.push_back(mk_a(0));
    rst = 1'b0;
    repeat (5) tick();
    ifa.req_valid_in = 4'b0000;
    tick();
    chk("rr_drained", 64'(qa.size()), 64'h0);
    ifa.out_ready_in = 1'b0;
    ifa.req_valid_in = 4'b1111;
    qa.push_back(mk_a(1));
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(ifa.out_valid_out), 64'h1);
      chk("bp_grant", 64'(ifa.grant_out), 64'h2);
      chk("bp_data", 64'({ifa.out_data_out, ifa.out_dest_out, ifa.out_vc_out}), 64'({d_a[1], dest_a[1], vc_a[1]}));
      chk("bp_ready", 64'(ifa.req_ready_out), 64'h0);
      tick();
    end
    ifa.out_ready_in = 1'b1;
    qa.push_back(mk_a(2));
    @(negedge clk);
    chk("bp_release_ready", 64'(ifa.req_ready_out), 64'h4);
    tick();
    ifa.req_valid_in = 4'b0000;
    tick();
    chk("bp_drained", 64'(qa.size()), 64'h0);
    d_a[3] = 32'hA5A5_0001;
    dest_a[3] = 4'd5;
    vc_a[3] = 1'b1;
    ifa.req_valid_in = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      qa.push_back(mk_a(3));
      @(negedge clk);
      chk("sparse_ready", 64'(ifa.req_ready_out), 64'h8);
      tick();
      d_a[3] = d_a[3] + 32'd1;
    end
    ifa.req_valid_in = 4'b0000;
    tick();
    chk("sparse_drained", 64'(qa.size()), 64'h0);
    qb.push_back(mk_b(0));
    qb.push_back(mk_b(0));
    qb.push_back(mk_b(0));
    qb.push_back(mk_b(2));
    qb.push_back(mk_b(2));
    qb.push_back(mk_b(2));
    qb.push_back(mk_b(0));
    ifb.req_valid_in = 4'b0101;
    repeat (7) tick();
    qb.push_back(mk_b(2));
    qb.push_back(mk_b(2));
    ifb.req_valid_in = 4'b0100;
    repeat (2) tick();
    ifb.req_valid_in = 4'b0000;
    tick();
    chk("burst_drained", 64'(qb.size()), 64'h0);
    ifb.out_ready_in = 1'b0;
    ifb.req_valid_in = 4'b0101;
    tick();
    @(negedge clk);
    chk("mid_full_valid", 64'(ifb.out_valid_out), 64'h1);
    chk("mid_full_grant", 64'(ifb.grant_out), 64'h4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 64'(ifb.out_valid_out), 64'h0);
    chk("mid_rst_grant", 64'(ifb.grant_out), 64'h0);
    rst = 1'b0;
    ifb.out_ready_in = 1'b1;
    qb.push_back(mk_b(0));
    tick();
    ifb.req_valid_in = 4'b0000;
    repeat (3) tick();
    chk("final_qa_empty", 64'(qa.size()), 64'h0);
    chk("final_qb_empty", 64'(qb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Shares one NoC router injection port among `NUM_REQ` traffic sources: via, tpg or similar blocks that each present data, dest, vc and valid, and accept ready.

- Arbitration is round-robin with an optional bounded burst lock.
- Each granted flit is captured into a single registered output stage that drives the router port.
- The block sits between a group of co-located simulation-model sources and the single router port they share (same `o*_NODE`).

## Interface

Parameters:
- `N`, 16: number of NoC nodes.
- `NUM_VC`, 2: number of virtual channels.
- `N_ADDR_WIDTH`, `$clog2(N)`: router address width.
- `VC_ADDR_WIDTH`, `$clog2(NUM_VC)`: VC index width.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: flit data width.
- `MAX_BURST`, 1: maximum consecutive flits one requester may send while holding the lock, 1..255. A value of 1 gives pure round-robin.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_data_in`  in  `NUM_REQ*WIDTH`  requester i data at `[i*WIDTH +: WIDTH]`.
- `req_dest_in`  in  `NUM_REQ*N_ADDR_WIDTH`  requester i destination router, same packing.
- `req_vc_in`  in  `NUM_REQ*VC_ADDR_WIDTH`  requester i destination VC, same packing.
- `req_valid_in`  in  `NUM_REQ`  requester i has a flit.
- `req_ready_out`  out  `NUM_REQ`  one-hot or zero; requester i's flit is taken this cycle.
- `out_data_out`  out  `WIDTH`  registered flit data to the router.
- `out_dest_out`  out  `N_ADDR_WIDTH`  registered destination.
- `out_vc_out`  out  `VC_ADDR_WIDTH`  registered VC.
- `out_valid_out`  out  1  output stage holds a flit.
- `out_ready_in`  in  1  router accepts the flit this cycle.
- `grant_out`  out  `NUM_REQ`  registered one-hot index of the requester whose flit is in the output stage. Zero when empty.

## Operation

- Transfer rules:
  - A requester-side transfer occurs when `req_valid_in[i] && req_ready_out[i]`.
  - An output-side transfer occurs when `out_valid_out && out_ready_in`.
- `load_en = !out_valid_out || out_ready_in`, which is combinational.
- `req_ready_out[g] = load_en && any_valid`, where g is the combinational winner. All other bits of `req_ready_out` are 0.
- Winner selection:
  - If `lock_valid`, `req_valid_in[owner]` is high and `burst_cnt < MAX_BURST`, then g = owner.
  - Otherwise g is the first i with `req_valid_in[i]` high, searching from `(owner+1) mod NUM_REQ` upward with wrap.
- State registers:
  - `owner` (`$clog2(NUM_REQ)` bits, reset to `NUM_REQ-1`, so requester 0 wins first).
  - `burst_cnt` (8 bits, reset 0).
  - `lock_valid` (reset 0).
- On a requester-side transfer by g:
  - If g == owner and `lock_valid`: `burst_cnt <= burst_cnt+1`.
  - Otherwise: `owner <= g`, `burst_cnt <= 1`, `lock_valid <= 1`.
  - The output stage loads the data, dest and vc slices of g, sets `out_valid_out <= 1` and sets `grant_out <= onehot(g)`.
- On an output-side transfer with no requester-side transfer: `out_valid_out <= 0`, `grant_out <= 0`. Data, dest and vc hold their last values.
- When the owner deasserts valid, the lock is released implicitly: the round-robin search starts at owner+1. `burst_cnt` is reset on the next grant.
- While `out_valid_out` is set and `out_ready_in` is low, the output fields are held stable and `req_ready_out` is 0.
- Data is passed through unmodified. The header fields embedded by the sources are not inspected.

## Timing

- Reset values: `out_valid_out`=0, `out_data_out`=0, `out_dest_out`=0, `out_vc_out`=0, `grant_out`=0, `req_ready_out`=0 while `rst` is high.
- Latency: a flit accepted at edge k appears on the `out_*` outputs after edge k (1 cycle).
- Throughput: 1 flit/cycle when `out_ready_in` is held high. Output-side and requester-side transfers in the same cycle are allowed, with no bubble.
- `req_ready_out` depends combinationally on `req_valid_in`, `out_ready_in` and state. Requesters must not make valid depend on ready.
- Asserting `rst` mid-transfer discards the output-stage flit and clears the lock. Requesters must re-present their flits.
- `MAX_BURST`=1 with a single active requester: that requester is still granted every cycle, because it is the only valid one.

## Test plan

- Reset: assert `rst` 2 cycles with all `req_valid_in`=4'b1111.
  - Required: `out_valid_out`, `grant_out` and `req_ready_out` are 0 during reset.
  - Required: the first grant after reset is requester 0.
- Round-robin: `NUM_REQ`=4, `MAX_BURST`=1, all valid, `out_ready_in`=1.
  - Required: `grant_out` sequence 0001, 0010, 0100, 1000, 0001, one grant per cycle.
  - Required: `out_data_out` matches the sender's slice 1 cycle after acceptance.
- Backpressure: hold `out_ready_in`=0 for 5 cycles with the stage full.
  - Required: `out_*` are stable and `req_ready_out`=0.
  - Required: on release, the held flit drains and the next winner loads in the same cycle.
- Burst lock: `MAX_BURST`=3, requesters 0 and 2 valid continuously.
  - Required: grant order 0,0,0,2,2,2,0.
  - Then drop requester 0's valid after 1 flit. Required: control passes to 2 the next cycle.
- Sparse traffic: only requester 3 valid, with dest=5, vc=1, data=`32'hA5A5_0001` incrementing.
  - Required: back-to-back acceptance and `out_dest_out`=5, `out_vc_out`=1 on each flit.
- Mid-operation reset: assert `rst` while the stage is full and the lock is held.
  - Required: `out_valid_out`=0 the next cycle.
  - Required: arbitration restarts at requester 0.
